// File: rtl/rv32i_soc_pkg.sv
// Shared constants and types for the RV32I memory-side responder.
// Covers MMIO register offsets, STATUS bit positions and the address region select.
package rv32i_soc_pkg;

  localparam logic [1:0] MMIO_TX_DATA = 2'd0;
  localparam logic [1:0] MMIO_STATUS  = 2'd1;
  localparam logic [1:0] MMIO_CYCLE   = 2'd2;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_COUNT_LSB = 4;
  localparam int unsigned STATUS_COUNT_W   = 4;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Console TX byte FIFO with registered head, occupancy count and full/empty flags.
// The head byte and flags depend only on registers, never on the pop request.
module tx_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rv32i_mem_responder.sv
// Memory-side responder for the RV32I core: byte-maskable RAM, console/status/cycle
// MMIO block and unmapped space, with one-cycle registered read data.
module rv32i_mem_responder
  import rv32i_soc_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
  parameter int unsigned TX_DEPTH  = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_wmask,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_hold,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(TX_DEPTH) + 1;

  region_e           region;
  logic [1:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              tx_write;
  logic              wr_accept;
  logic [3:0]        ram_we;
  logic              tx_full;
  logic              tx_empty;
  logic [CNT_W-1:0]  tx_count;
  logic [31:0]       status_word;
  logic [31:0]       cycle_q;
  logic [31:0]       ram [RAM_WORDS];
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^cpu_addr[1:0];
  assign mmio_off         = cpu_addr[3:2];
  assign ram_idx          = cpu_addr[RAM_AW+1:2];

  // Region decode on the word address.
  always_comb begin
    region = REGION_NONE;
    if (cpu_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]) begin
      region = REGION_RAM;
    end else if (cpu_addr[31:4] == MMIO_BASE[31:4]) begin
      region = REGION_MMIO;
    end
  end

  assign tx_write  = (region == REGION_MMIO) && (mmio_off == MMIO_TX_DATA) && cpu_wmask[0];
  assign cpu_hold  = !reset && tx_write && tx_full;
  // A write landing in a reset cycle is dropped along with everything else.
  assign wr_accept = (cpu_wmask != 4'b0000) && !cpu_hold && !reset;
  assign ram_we    = (wr_accept && (region == REGION_RAM)) ? cpu_wmask : 4'b0000;
  assign tx_valid  = !tx_empty;

  tx_byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_accept && tx_write),
    .push_data (cpu_wdata[7:0]),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_comb begin
    status_word                                     = '0;
    status_word[STATUS_FULL_BIT]                    = tx_full;
    status_word[STATUS_EMPTY_BIT]                   = tx_empty;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(tx_count);
  end

  // RAM contents survive reset; lanes are written independently.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) ram[ram_idx][8*i +: 8] <= cpu_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  // Read-first: a same-cycle RAM write is visible one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata <= '0;
    end else begin
      case (region)
        REGION_RAM: cpu_rdata <= ram[ram_idx];
        REGION_MMIO: begin
          case (mmio_off)
            MMIO_STATUS: cpu_rdata <= status_word;
            MMIO_CYCLE:  cpu_rdata <= cycle_q;
            default:     cpu_rdata <= '0;
          endcase
        end
        default: cpu_rdata <= '0;
      endcase
    end
  end

endmodule
